// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply controller and its serial multiplier.
//   DATA_W       : operand width (32)
//   ctrl_state_t : controller FSM encoding (IDLE -> RUN -> WB -> IDLE)
package mult_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/mult.sv
// Serial shift-add unsigned multiplier, one multiplier bit per cycle.
// Terminates early once the remaining multiplier bits are all zero, so the
// caller should present the smaller operand on op1.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   op1, op2  : unsigned multiplier / multiplicand (read while idle and go=1)
//   go        : request; a new operation starts when idle and go=1
//   res       : 64-bit product, valid in the first cycle hold drops while go=1
//   hold      : 1 while the product is not yet ready
module mult
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     op1,
  input  logic [DATA_W-1:0]     op2,
  input  logic                  go,
  output logic [2*DATA_W-1:0]   res,
  output logic                  hold
);

  logic                calc_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      calc_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (!calc_q) begin
      if (go) begin
        // The load cycle already folds in multiplier bit 0.
        calc_q   <= 1'b1;
        acc_q    <= op1[0] ? {{DATA_W{1'b0}}, op2} : '0;
        mcand_q  <= {{(DATA_W-1){1'b0}}, op2, 1'b0};
        mplier_q <= op1 >> 1;
      end
    end else if (mplier_q != '0) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end else begin
      // Result is presented this cycle; back to idle for the next request.
      calc_q <= 1'b0;
    end
  end

  assign hold = calc_q ? (mplier_q != '0) : go;
  assign res  = acc_q;

endmodule

// File: rtl/mult_ctrl.sv
// MULT/MULTU controller owning the architectural HI/LO registers.
// Converts signed operands to magnitudes, presents the smaller magnitude to
// the serial multiplier as its op1, and applies the sign on write-back.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (also resets mult)
//   start         : one-cycle multiply request (op1, op2, is_signed sampled)
//   is_signed     : 1 = MULT (two's complement), 0 = MULTU
//   op1, op2      : 32-bit operands
//   mthi, mtlo    : write wdata into HI / LO (only while idle)
//   wdata         : data for mthi/mtlo
//   rd_hilo       : pipeline reads HI/LO this cycle (affects stall only)
//   hi, lo        : architectural HI/LO registers
//   busy          : multiply in flight
//   stall         : any HI/LO-related request while busy
module mult_ctrl
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_hilo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall
);

  // |v| for signed operands; |-2^31| wraps to 0x8000_0000, which is the
  // correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              sgn);
    logic [DATA_W-1:0] m;
    m = v;
    if (sgn && v[DATA_W-1]) m = -v;
    return m;
  endfunction

  ctrl_state_t state_q, state_d;

  logic                busy_q, go_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic [DATA_W-1:0]   mop1_q, mop2_q;
  logic                sgn_q, s1_q, s2_q;
  logic [2*DATA_W-1:0] prod_q;

  logic                accept, capture, writeback;
  logic [DATA_W-1:0]   mag1, mag2;
  logic                swap, neg;
  logic [2*DATA_W-1:0] wb_val;
  logic [2*DATA_W-1:0] mul_res;
  logic                mul_hold;

  assign mag1   = magnitude(op1, is_signed);
  assign mag2   = magnitude(op2, is_signed);
  // Ties keep the original order.
  assign swap   = (mag2 < mag1);
  assign neg    = sgn_q & (s1_q ^ s2_q);
  assign wb_val = neg ? -prod_q : prod_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    writeback = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!mul_hold) begin
          capture = 1'b1;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        writeback = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      go_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      mop1_q <= '0;
      mop2_q <= '0;
      sgn_q  <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      if (accept) begin
        mop1_q <= swap ? mag2 : mag1;
        mop2_q <= swap ? mag1 : mag2;
        sgn_q  <= is_signed;
        s1_q   <= op1[DATA_W-1];
        s2_q   <= op2[DATA_W-1];
        busy_q <= 1'b1;
        go_q   <= 1'b1;
      end else if (state_q == ST_IDLE) begin
        // A start in the same cycle wins over mt writes (handled above).
        if (mthi) hi_q <= wdata;
        if (mtlo) lo_q <= wdata;
      end
      if (capture) begin
        prod_q <= mul_res;
        go_q   <= 1'b0;
      end
      if (writeback) begin
        {hi_q, lo_q} <= wb_val;
        busy_q       <= 1'b0;
      end
    end
  end

  mult u_mult (
    .clk  (clk),
    .rst  (rst),
    .op1  (mop1_q),
    .op2  (mop2_q),
    .go   (go_q),
    .res  (mul_res),
    .hold (mul_hold)
  );

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign stall = (start | mthi | mtlo | rd_hilo) & busy_q;

endmodule

// File: tb/tb_mult_ctrl.sv
module tb_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_signed, mthi, mtlo, rd_hilo;
  logic [31:0] op1, op2, wdata;
  logic [31:0] hi, lo;
  logic        busy, stall;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq[$];

  always #5 clk = ~clk;

  mult_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op1       (op1),
    .op2       (op2),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .rd_hilo   (rd_hilo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int msb_idx(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic int expected_busy(input logic [31:0] a, input logic [31:0] b,
                                       input logic sgn);
    logic [31:0] ma, mb;
    ma = (sgn && a[31]) ? (~a + 32'd1) : a;
    mb = (sgn && b[31]) ? (~b + 32'd1) : b;
    return 3 + msb_idx((ma < mb) ? ma : mb);
  endfunction

  // Called at a falling edge (cycle 0); returns at the falling edge of the
  // first cycle with busy low, after checking busy length and HI/LO.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn);
    int n;
    logic [63:0] exp;
    sbq.push_back(model_prod(a, b, sgn));
    op1 = a; op2 = b; is_signed = sgn; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op1 = $urandom; op2 = $urandom; is_signed = 1'($urandom_range(0, 1));
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 64'(n), 64'(expected_busy(a, b, sgn)));
    exp = sbq.pop_front();
    check({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [31:0] prev_hi;
    int n;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    rd_hilo = 1'b0; op1 = '0; op2 = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_mul("u3x5", 32'd3, 32'd5, 1'b0);
    run_mul("s_m7x6", 32'hFFFF_FFF9, 32'd6, 1'b1);
    run_mul("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_mul("u_max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mul("u_swap_a", 32'h0001_0000, 32'd3, 1'b0);
    run_mul("u_swap_b", 32'd3, 32'h0001_0000, 1'b0);
    run_mul("u_zero", 32'd0, 32'd5, 1'b0);
    run_mul("s_m1x1", 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_mul("s_tie", 32'hFFFF_FF00, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 6; i++)
      run_mul("rand", $urandom, $urandom_range(0, 32'h0000_FFFF), 1'(i % 2));

    // Requests while busy: stall, no effect on HI, second start dropped.
    @(negedge clk);
    prev_hi = hi;
    sbq.push_back(model_prod(32'h1234, 32'h100, 1'b0));
    op1 = 32'h1234; op2 = 32'h100; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rd_hilo = 1'b1;
    #1 check("stall_rd", 64'(stall), 64'd1);
    @(negedge clk);
    rd_hilo = 1'b0; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    #1 check("stall_mthi", 64'(stall), 64'd1);
    @(negedge clk);
    mthi = 1'b0;
    check("hi_kept", 64'(hi), 64'(prev_hi));
    op1 = 32'd5; op2 = 32'd5; start = 1'b1;
    #1 check("stall_start", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("stall_run_done", 64'(n < 200), 64'd1);
    check("stall_run_hilo", {hi, lo}, sbq.pop_front());
    @(negedge clk);
    check("second_start_ignored", 64'(busy), 64'd0);

    // Idle HI/LO moves.
    mtlo = 1'b1; wdata = 32'h0000_ABCD;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo", 64'(lo), 64'h0000_ABCD);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_1234;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    check("mt_both", {hi, lo}, {32'h5A5A_1234, 32'h5A5A_1234});
    mthi = 1'b1; wdata = 32'hFFFF_FFFF;
    run_mul("start_beats_mthi", 32'd2, 32'd3, 1'b0);

    // Reset in the third RUN cycle aborts without a HI/LO write.
    run_mul("pre_abort", 32'hFFFF_FFFF, 32'd7, 1'b0);
    op1 = 32'hFFFF; op2 = 32'hFFFF; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_mul("after_rst_2x2", 32'd2, 32'd2, 1'b0);
    run_mul("back_to_back", 32'd9, 32'hFFFF_FFF0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (clk, rst).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset; also drives the embedded multiplier's rst.
REQ-004 start  input  1  single-cycle request to begin a multiply of op1*op2.
REQ-005 is_signed  input  1  sampled with start; 1 = two's-complement MULT, 0 = MULTU.
REQ-006 op1, op2  input  32 each  operands, sampled on the start cycle.
REQ-007 mthi, mtlo  input  1 each  write wdata to HI / LO.
REQ-008 wdata  input  32  data for mthi/mtlo.
REQ-009 rd_hilo  input  1  pipeline reads HI/LO this cycle.
REQ-010 hi, lo  output  32 each  architectural HI/LO registers (registered).
REQ-011 busy  output  1  a multiply is in flight (registered).
REQ-012 stall  output  1  combinational: (start | mthi | mtlo | rd_hilo) & busy.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, WB; reset state IDLE.
REQ-014 In IDLE, start SHALL latch the operands, sign info and is_signed, set busy, and go to RUN.
REQ-015 For a signed operation, the block SHALL pass |op1| and |op2| to the multiplier; |-2^31| = 0x8000_0000 unsigned. It SHALL record neg = op1[31] ^ op2[31].
REQ-016 The block SHALL pass the smaller-magnitude operand as the multiplier's op1; ties SHALL pass op1 unchanged.
REQ-017 In RUN, the multiplier go signal SHALL be held at 1 every cycle.
REQ-018 In the first RUN cycle in which the multiplier hold is 0, the block SHALL capture its 64-bit res, deassert go from the next cycle, and enter WB.
REQ-019 In WB, the block SHALL write {hi,lo} = neg ? -product : product (64-bit two's complement), clear busy, and return to IDLE.
REQ-020 Latency: for a start in cycle 0 whose smaller magnitude has MSB index p (p=0 for values 0 and 1), busy SHALL be high in cycles 1..3+p, and new hi/lo SHALL be visible in cycle 4+p.
REQ-021 A start, mthi or mtlo while busy SHALL be ignored (the requester sees stall and holds).
REQ-022 In IDLE, start together with mthi/mtlo: start SHALL win and the mt write SHALL be discarded.
REQ-023 In IDLE, mthi and mtlo in the same cycle SHALL both write.
REQ-024 rd_hilo SHALL have no side effect other than stall.
REQ-025 A start in the cycle immediately after busy falls SHALL be accepted; the embedded multiplier is ready by then.

Reset
REQ-026 rst SHALL force state IDLE, hi=0, lo=0, busy=0, go=0, and clear the latched operands and neg.
REQ-027 rst in RUN or WB SHALL abort the operation, with no HI/LO write. The embedded multiplier is reset in the same cycle.
REQ-028 The first start after rst deasserts SHALL be accepted.

Structure
REQ-029 The state encoding and the operand width (32) SHALL live in a shared package, mult_pkg.
REQ-030 The existing serial multiplier SHALL be instantiated as the sole sub-module, mult (ports clk, rst, op1, op2, go, res, hold). All sign, swap and HI/LO logic SHALL stay in mult_ctrl.

Verification
REQ-031 Unsigned 3*5, start in cycle 0 -> busy in cycles 1..4; hi=0, lo=15 in cycle 5.
REQ-032 Signed -7*6 -> {hi,lo}=0xFFFFFFFF_FFFFFFD6; busy length matches p of 6 (p=2).
REQ-033 Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0. Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1.
REQ-034 Swap check: unsigned 0x10000*3 -> busy length identical to 3*0x10000 (p=1); lo=0x30000.
REQ-035 rd_hilo, mthi and start asserted mid-run -> stall=1 each cycle; HI unchanged by the mthi; second start ignored. mtlo 0xABCD in IDLE -> lo=0xABCD the next cycle.
REQ-036 rst asserted in the third RUN cycle of 0xFFFF*0xFFFF -> hi=lo=0, busy=0 the next cycle. A following 2*2 yields lo=4.
